// File: rtl/if_instr_mem_pipe.sv
// if_instr_mem_pipe: writable IF-stage instruction RAM with 1/2-cycle pipelined fetch,
// stall/flush control and PC-tagged fault reporting for misaligned or out-of-range fetches.
module if_instr_mem_pipe #(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 32,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fault
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] LIMIT = (ADDR_W-2)'(DEPTH);
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("if_instr_mem_pipe: LATENCY must be 1 or 2");
  end
  logic [31:0] ram [DEPTH] = '{default: NOP_INSTR};
  logic [ADDR_W-3:0] ridx, widx;
  logic r_fault, w_ok, accept;
  logic [31:0] r_word;
  logic s1_valid, s1_fault, n_valid, n_fault;
  logic [31:0] s1_instr, n_instr;
  logic [ADDR_W-1:0] s1_pc, n_pc;
  assign ridx = i_addr[ADDR_W-1:2];
  assign widx = i_waddr[ADDR_W-1:2];
  assign r_fault = (|i_addr[1:0]) || ridx >= LIMIT;
  assign r_word = r_fault ? NOP_INSTR : ram[ridx[IW-1:0]];
  assign w_ok = i_we && !(|i_waddr[1:0]) && widx < LIMIT;
  assign accept = i_req && !i_stall;
  // Nonblocking write keeps same-edge reads on the old word (read-first).
  always_ff @(posedge i_clk)
    if (w_ok && !i_rst) ram[widx[IW-1:0]] <= i_wdata;
  always_comb begin
    n_valid = LATENCY == 1 ? accept : s1_valid && !i_flush;
    n_fault = LATENCY == 1 ? r_fault : s1_fault;
    n_instr = LATENCY == 1 ? r_word : s1_instr;
    n_pc    = LATENCY == 1 ? i_addr : s1_pc;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_fault <= 1'b0;
      s1_instr <= NOP_INSTR;
      s1_pc    <= '0;
      o_valid  <= 1'b0;
      o_fault  <= 1'b0;
      o_instr  <= NOP_INSTR;
      o_pc     <= '0;
    end else if (i_flush || !i_stall) begin
      s1_valid <= accept;
      s1_fault <= accept && r_fault;
      s1_instr <= accept ? r_word : NOP_INSTR;
      if (accept) s1_pc <= i_addr;
      o_valid  <= n_valid;
      o_fault  <= n_valid && n_fault;
      o_instr  <= n_valid ? n_instr : NOP_INSTR;
      if (n_valid) o_pc <= n_pc;
    end
endmodule

// File: tb/tb_if_instr_mem_pipe.sv
// tb_if_instr_mem_pipe: scoreboard bench driving LATENCY=1 and LATENCY=2 instances in lockstep.
module tb_if_instr_mem_pipe;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0 = 32'h00100093, W1 = 32'h00110113, W2 = 32'h00208193;
  localparam logic [31:0] W3 = 32'h11111111, W10 = 32'h02a00513, NEW = 32'hDEADBEEF;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;
  logic clk = 0, rst = 1, req = 0, stall = 0, flush = 0, we = 0, adv = 0;
  logic [31:0] addr = 0, waddr = 0, wdata = 0;
  logic v1, f1, v2, f2;
  logic [31:0] i1, p1, i2, p2;
  int total = 0, passed = 0;
  exp_t q1[$], q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;

  if_instr_mem_pipe #(.DEPTH(16), .ADDR_W(32), .LATENCY(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_stall(stall), .i_flush(flush),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .o_valid(v1), .o_instr(i1), .o_pc(p1), .o_fault(f1));
  if_instr_mem_pipe #(.DEPTH(16), .ADDR_W(32), .LATENCY(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_stall(stall), .i_flush(flush),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .o_valid(v2), .o_instr(i2), .o_pc(p2), .o_fault(f2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // A new output is presented only after an edge where the pipeline advanced.
  always @(posedge clk) adv <= !rst && (!stall || flush);

  always @(negedge clk)
    if (adv && v1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL u1_spurious: got valid pc %h expected no output", p1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_pc", p1, e1.pc);
        chk("u1_instr", i1, e1.instr);
        chk("u1_fault", {31'd0, f1}, {31'd0, e1.fault});
      end
    end

  always @(negedge clk)
    if (adv && v2) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL u2_spurious: got valid pc %h expected no output", p2);
      end else begin
        e2 = q2.pop_front();
        chk("u2_pc", p2, e2.pc);
        chk("u2_instr", i2, e2.instr);
        chk("u2_fault", {31'd0, f2}, {31'd0, e2.fault});
      end
    end

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] w,
                      input logic s = 0, input logic fl = 0, input logic e = 0,
                      input logic [31:0] wa = 0, input logic [31:0] wd = 0);
    exp_t x;
    req = r; addr = a; stall = s; flush = fl; we = e; waddr = wa; wdata = wd;
    if (fl) begin q1.delete(); q2.delete(); end
    if (r && !s) begin
      x.pc = a;
      x.fault = (a[1:0] != 2'b00) || a >= 32'd64;
      x.instr = x.fault ? NOP : w;
      q1.push_back(x);
      q2.push_back(x);
    end
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 1, a, d);
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_v1", {31'd0, v1}, 0);
    chk("rst_i1", i1, NOP);
    chk("rst_p1", p1, 0);
    chk("rst_f1", {31'd0, f1}, 0);
    chk("rst_v2", {31'd0, v2}, 0);
    chk("rst_i2", i2, NOP);
    rst = 0;
    wr(0, W0); wr(4, W1); wr(8, W2); wr(12, W3); wr(40, W10); wr(64, 32'hBADBAD00);
    step(1, 0, W0);
    chk("lat1_first_v", {31'd0, v1}, 1);
    chk("lat2_not_yet_v", {31'd0, v2}, 0);
    step(1, 4, W1);
    chk("lat1_b2b_pc", p1, 4);
    chk("lat2_first_pc", p2, 0);
    step(0, 0, 0);
    chk("lat2_second_pc", p2, 4);
    step(0, 0, 0);
    step(1, 8, W2);
    chk("lat2_addr8_pending", {31'd0, v2}, 0);
    step(0, 0, 0);
    chk("lat2_addr8_v", {31'd0, v2}, 1);
    chk("lat2_addr8_instr", i2, W2);
    repeat (3) begin
      step(1, 60, 0, 1);
      chk("stall_hold_v", {31'd0, v2}, 1);
      chk("stall_hold_instr", i2, W2);
      chk("stall_hold_pc", p2, 8);
      chk("stall_l1_idle", {31'd0, v1}, 0);
    end
    step(0, 0, 0);
    chk("stall_release_v", {31'd0, v2}, 0);
    step(1, 6, 0);
    chk("misalign_fault", {31'd0, f1}, 1);
    step(1, 64, 0);
    chk("range_fault_pc", p1, 64);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, W0);
    step(1, 4, W1);
    step(1, 40, W10, 0, 1);
    chk("flush_kill_v2", {31'd0, v2}, 0);
    chk("flush_redirect_l1_pc", p1, 40);
    step(0, 0, 0);
    chk("flush_redirect_l2_pc", p2, 40);
    step(0, 0, 0);
    step(1, 12, W3, 0, 0, 1, 12, NEW);
    step(1, 12, NEW, 0, 0, 1, 13, 32'hBAD0BAD0);
    step(1, 12, NEW);
    step(1, 0, W0);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 4, W1);
    req = 1; addr = 8; we = 1; waddr = 0; wdata = 32'hFFFFFFFF;
    #1 rst = 1;
    #1;
    chk("async_rst_v1", {31'd0, v1}, 0);
    chk("async_rst_i1", i1, NOP);
    chk("async_rst_v2", {31'd0, v2}, 0);
    chk("async_rst_i2", i2, NOP);
    q1.delete(); q2.delete();
    @(negedge clk); #1;
    rst = 0; req = 0; we = 0;
    step(1, 0, W0);
    step(0, 0, 0); step(0, 0, 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
